// File: rtl/instr_encode_and_pack.sv
// RV32I instruction encoder: decoded fields in, packed 32-bit words out, each
// stamped with a word-aligned write address. Two-stage valid/ready pipeline.
module instr_encode_and_pack #(
    parameter int                    INST_SIZE  = 32,
    parameter int                    DATA_SIZE  = 32,
    parameter logic [DATA_SIZE-1:0]  RESET_ADDR = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [6:0]           i_opcode,
    input  logic [4:0]           i_rd,
    input  logic [4:0]           i_rs1,
    input  logic [4:0]           i_rs2,
    input  logic [2:0]           i_funct3,
    input  logic [6:0]           i_funct7,
    input  logic [DATA_SIZE-1:0] i_immediate,
    input  logic                 i_addr_load,
    input  logic [DATA_SIZE-1:0] i_addr_base,
    input  logic                 i_err_clr,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [INST_SIZE-1:0] o_instr,
    output logic [DATA_SIZE-1:0] o_addr,
    output logic                 o_err,
    output logic                 o_err_sticky
);

    typedef enum logic [6:0] {
        OP_LOADS    = 7'b0000011,
        OP_ALC_I    = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORES   = 7'b0100011,
        OP_ALC_R    = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCHES = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111
    } t_opcode;

    localparam logic [INST_SIZE-1:0] NOP = INST_SIZE'(32'h0000_0013);

    logic                 s1_valid_reg;
    logic [6:0]           s1_opcode_reg;
    logic [4:0]           s1_rd_reg;
    logic [4:0]           s1_rs1_reg;
    logic [4:0]           s1_rs2_reg;
    logic [2:0]           s1_funct3_reg;
    logic [6:0]           s1_funct7_reg;
    logic [DATA_SIZE-1:0] s1_imm_reg;
    logic [DATA_SIZE-1:0] addr_cnt_reg;

    logic                 s2_adv;
    logic                 s1_xfer;
    logic                 fit_i;
    logic                 fit_b;
    logic                 fit_j;
    logic                 fit_u;
    logic [INST_SIZE-1:0] enc_instr_next;
    logic                 enc_err_next;

    assign s2_adv  = !o_valid || i_ready;
    assign o_ready = !s1_valid_reg || s2_adv;
    assign s1_xfer = s1_valid_reg && s2_adv;

    // A value fits a signed field when every bit above the field's sign bit
    // equals that sign bit.
    assign fit_i = (&s1_imm_reg[31:11]) || !(|s1_imm_reg[31:11]);
    assign fit_b = ((&s1_imm_reg[31:12]) || !(|s1_imm_reg[31:12])) && !s1_imm_reg[0];
    assign fit_j = ((&s1_imm_reg[31:20]) || !(|s1_imm_reg[31:20])) && !s1_imm_reg[0];
    assign fit_u = !(|s1_imm_reg[11:0]);

    always_comb begin
        enc_instr_next = '0;
        enc_err_next   = 1'b0;
        case (s1_opcode_reg)
            OP_LOADS, OP_ALC_I, OP_JALR: begin
                enc_instr_next = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg,
                                  s1_rd_reg, s1_opcode_reg};
                enc_err_next   = !fit_i;
            end
            OP_ALC_R: begin
                enc_instr_next = {s1_funct7_reg, s1_rs2_reg, s1_rs1_reg,
                                  s1_funct3_reg, s1_rd_reg, s1_opcode_reg};
            end
            OP_STORES: begin
                enc_instr_next = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg,
                                  s1_funct3_reg, s1_imm_reg[4:0], s1_opcode_reg};
                enc_err_next   = !fit_i;
            end
            OP_BRANCHES: begin
                enc_instr_next = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg,
                                  s1_rs1_reg, s1_funct3_reg, s1_imm_reg[4:1],
                                  s1_imm_reg[11], s1_opcode_reg};
                enc_err_next   = !fit_b;
            end
            OP_LUI, OP_AUIPC: begin
                enc_instr_next = {s1_imm_reg[31:12], s1_rd_reg, s1_opcode_reg};
                enc_err_next   = !fit_u;
            end
            OP_JAL: begin
                enc_instr_next = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                                  s1_imm_reg[19:12], s1_rd_reg, s1_opcode_reg};
                enc_err_next   = !fit_j;
            end
            default: enc_err_next = 1'b1;
        endcase
        if (enc_err_next) begin
            enc_instr_next = NOP;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_opcode_reg <= '0;
            s1_rd_reg     <= '0;
            s1_rs1_reg    <= '0;
            s1_rs2_reg    <= '0;
            s1_funct3_reg <= '0;
            s1_funct7_reg <= '0;
            s1_imm_reg    <= '0;
            addr_cnt_reg  <= RESET_ADDR;
            o_valid       <= 1'b0;
            o_instr       <= '0;
            o_addr        <= '0;
            o_err         <= 1'b0;
            o_err_sticky  <= 1'b0;
        end else begin
            if (o_ready) begin
                s1_valid_reg <= i_valid;
                if (i_valid) begin
                    s1_opcode_reg <= i_opcode;
                    s1_rd_reg     <= i_rd;
                    s1_rs1_reg    <= i_rs1;
                    s1_rs2_reg    <= i_rs2;
                    s1_funct3_reg <= i_funct3;
                    s1_funct7_reg <= i_funct7;
                    s1_imm_reg    <= i_immediate;
                end
            end
            if (s2_adv) begin
                o_valid <= s1_valid_reg;
                if (s1_valid_reg) begin
                    o_instr <= enc_instr_next;
                    o_addr  <= addr_cnt_reg;
                    o_err   <= enc_err_next;
                end
            end
            // A load overrides the increment; the transferring word already took the old value.
            if (i_addr_load) begin
                addr_cnt_reg <= {i_addr_base[DATA_SIZE-1:2], 2'b00};
            end else if (s1_xfer) begin
                addr_cnt_reg <= addr_cnt_reg + DATA_SIZE'(4);
            end
            if (s1_xfer && enc_err_next) begin
                o_err_sticky <= 1'b1;
            end else if (i_err_clr) begin
                o_err_sticky <= 1'b0;
            end
        end
    end

endmodule
